// File: rtl/otter_pkg.sv
// -----------------------------------------------------------------------------
// otter_pkg
// Shared types and constants for the OTTER pipeline sequencing controller.
//   fwd_sel_t : ALU operand source select (RF/DE value, EX/MEM result, MEM/WB data)
//   REG_X0    : hard-wired zero register address, never forwarded or hazarded on
//   regHit    : "this source is read and matches that destination" helper
// -----------------------------------------------------------------------------
package otter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_W      = 2;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    // True when a used source register equals a destination register.
    function automatic logic regHit(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/otter_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// otter_pipe_ctrl_if
// Bundle between the OTTER datapath and its sequencing controller.
//   master : datapath side, drives stage register fields, receives stalls/valids
//   slave  : controller side (otter_pipe_ctrl)
// Inputs to the controller : DE/EX/MEM/WB register fields, BR_TAKEN, MEM_BUSY, CNT_CLR
// Outputs of the controller: STALL_*, *_VALID, FWD_*_SEL, DMEM_WE, RF_WE, counters
// -----------------------------------------------------------------------------
interface otter_pipe_ctrl_if
    import otter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic [REG_ADDR_W-1:0] DE_RS1;
    logic [REG_ADDR_W-1:0] DE_RS2;
    logic                  DE_RS1_USED;
    logic                  DE_RS2_USED;
    logic [REG_ADDR_W-1:0] EX_RS1;
    logic [REG_ADDR_W-1:0] EX_RS2;
    logic                  EX_RS1_USED;
    logic                  EX_RS2_USED;
    logic [REG_ADDR_W-1:0] EX_RD;
    logic                  EX_REG_WRITE;
    logic                  EX_MEM_READ;
    logic                  BR_TAKEN;
    logic [REG_ADDR_W-1:0] MEM_RD;
    logic                  MEM_REG_WRITE;
    logic                  MEM_MEM_READ;
    logic                  MEM_MEM_WRITE;
    logic [REG_ADDR_W-1:0] WB_RD;
    logic                  WB_REG_WRITE;
    logic                  MEM_BUSY;
    logic                  CNT_CLR;

    logic                  STALL_PC;
    logic                  STALL_IF;
    logic                  STALL_DE;
    logic                  STALL_EX;
    logic                  STALL_MEM;
    logic                  STALL_WB;
    logic                  IF_DE_VALID;
    logic                  DE_EX_VALID;
    logic                  EX_MEM_VALID;
    logic                  MEM_WB_VALID;
    logic [FWD_W-1:0]      FWD_A_SEL;
    logic [FWD_W-1:0]      FWD_B_SEL;
    logic                  DMEM_WE;
    logic                  RF_WE;
    logic [CNT_W-1:0]      STALL_CNT;
    logic [CNT_W-1:0]      FLUSH_CNT;

    modport master (
        output DE_RS1, DE_RS2, DE_RS1_USED, DE_RS2_USED,
               EX_RS1, EX_RS2, EX_RS1_USED, EX_RS2_USED,
               EX_RD, EX_REG_WRITE, EX_MEM_READ, BR_TAKEN,
               MEM_RD, MEM_REG_WRITE, MEM_MEM_READ, MEM_MEM_WRITE,
               WB_RD, WB_REG_WRITE, MEM_BUSY, CNT_CLR,
        input  STALL_PC, STALL_IF, STALL_DE, STALL_EX, STALL_MEM, STALL_WB,
               IF_DE_VALID, DE_EX_VALID, EX_MEM_VALID, MEM_WB_VALID,
               FWD_A_SEL, FWD_B_SEL, DMEM_WE, RF_WE, STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  DE_RS1, DE_RS2, DE_RS1_USED, DE_RS2_USED,
               EX_RS1, EX_RS2, EX_RS1_USED, EX_RS2_USED,
               EX_RD, EX_REG_WRITE, EX_MEM_READ, BR_TAKEN,
               MEM_RD, MEM_REG_WRITE, MEM_MEM_READ, MEM_MEM_WRITE,
               WB_RD, WB_REG_WRITE, MEM_BUSY, CNT_CLR,
        output STALL_PC, STALL_IF, STALL_DE, STALL_EX, STALL_MEM, STALL_WB,
               IF_DE_VALID, DE_EX_VALID, EX_MEM_VALID, MEM_WB_VALID,
               FWD_A_SEL, FWD_B_SEL, DMEM_WE, RF_WE, STALL_CNT, FLUSH_CNT
    );

endinterface

// File: rtl/otter_fwd_unit.sv
// -----------------------------------------------------------------------------
// otter_fwd_unit
// Combinational ALU operand source select for one EX operand.
//   exRs/exRsUsed          : source register of the EX instruction
//   memValid/RegWrite/MemRead/Rd : EX/MEM producer
//   wbValid/RegWrite/Rd    : MEM/WB producer
//   fwdSel                 : FWD_RF / FWD_EXMEM / FWD_MEMWB
// -----------------------------------------------------------------------------
module otter_fwd_unit
    import otter_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] exRs,
    input  logic                  exRsUsed,
    input  logic                  memValid,
    input  logic                  memRegWrite,
    input  logic                  memMemRead,
    input  logic [REG_ADDR_W-1:0] memRd,
    input  logic                  wbValid,
    input  logic                  wbRegWrite,
    input  logic [REG_ADDR_W-1:0] wbRd,
    output fwd_sel_t              fwdSel
);

    // Nearer producer wins; a load in EX/MEM has no ALU result worth taking,
    // so it falls through to MEM/WB (the load-use stall guarantees it is there).
    always_comb begin
        fwdSel = FWD_RF;
        if (exRsUsed && (exRs != REG_X0)) begin
            if (memValid && memRegWrite && !memMemRead && (memRd == exRs)) begin
                fwdSel = FWD_EXMEM;
            end else if (wbValid && wbRegWrite && (wbRd == exRs)) begin
                fwdSel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// otter_pipe_ctrl
// Sequencing controller for the 5-stage OTTER pipeline.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus (slave)  : stage register fields and status in; stalls, stage valids,
//                  forwarding selects, write-enable gating and saturating
//                  stall/flush counters out
// Priority: memory freeze > taken-branch flush > load-use stall.
// -----------------------------------------------------------------------------
module otter_pipe_ctrl
    import otter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    otter_pipe_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             ifDeValid;
    logic             deExValid;
    logic             exMemValid;
    logic             memWbValid;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    logic             freeze;
    logic             flush;
    logic             loadUse;
    logic             luRaw;
    logic             frontStall;
    fwd_sel_t         fwdA;
    fwd_sel_t         fwdB;
    logic             unusedSigs;

    // Hazard terms, already reduced by priority.
    always_comb begin
        luRaw   = deExValid && bus.EX_MEM_READ && (bus.EX_RD != REG_X0) && ifDeValid &&
                  (regHit(bus.DE_RS1_USED, bus.DE_RS1, bus.EX_RD) ||
                   regHit(bus.DE_RS2_USED, bus.DE_RS2, bus.EX_RD));
        freeze  = bus.MEM_BUSY;
        flush   = !freeze && bus.BR_TAKEN && deExValid;
        loadUse = !freeze && !flush && luRaw;
        frontStall = freeze || loadUse;
    end

    // Stalls are combinational; forced low while reset is asserted.
    assign bus.STALL_PC  = RESET_N && frontStall;
    assign bus.STALL_IF  = RESET_N && frontStall;
    assign bus.STALL_DE  = RESET_N && frontStall;
    assign bus.STALL_EX  = RESET_N && freeze;
    assign bus.STALL_MEM = RESET_N && freeze;
    assign bus.STALL_WB  = RESET_N && freeze;

    // Stage valid bits; a freeze holds everything.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ifDeValid  <= 1'b0;
            deExValid  <= 1'b0;
            exMemValid <= 1'b0;
            memWbValid <= 1'b0;
        end else if (!freeze) begin
            if (flush) begin
                // Squash the two younger instructions; the branch moves on.
                ifDeValid  <= 1'b0;
                deExValid  <= 1'b0;
                exMemValid <= 1'b1;
                memWbValid <= exMemValid;
            end else if (loadUse) begin
                // Consumer waits in DE, bubble enters EX.
                deExValid  <= 1'b0;
                exMemValid <= deExValid;
                memWbValid <= exMemValid;
            end else begin
                ifDeValid  <= 1'b1;
                deExValid  <= ifDeValid;
                exMemValid <= deExValid;
                memWbValid <= exMemValid;
            end
        end
    end

    // Saturating performance counters; clear beats increment.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (bus.CNT_CLR) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (frontStall && (stallCnt != CNT_MAX)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (flush && (flushCnt != CNT_MAX)) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

    otter_fwd_unit uFwdA (
        .exRs        (bus.EX_RS1),
        .exRsUsed    (bus.EX_RS1_USED),
        .memValid    (exMemValid),
        .memRegWrite (bus.MEM_REG_WRITE),
        .memMemRead  (bus.MEM_MEM_READ),
        .memRd       (bus.MEM_RD),
        .wbValid     (memWbValid),
        .wbRegWrite  (bus.WB_REG_WRITE),
        .wbRd        (bus.WB_RD),
        .fwdSel      (fwdA)
    );

    otter_fwd_unit uFwdB (
        .exRs        (bus.EX_RS2),
        .exRsUsed    (bus.EX_RS2_USED),
        .memValid    (exMemValid),
        .memRegWrite (bus.MEM_REG_WRITE),
        .memMemRead  (bus.MEM_MEM_READ),
        .memRd       (bus.MEM_RD),
        .wbValid     (memWbValid),
        .wbRegWrite  (bus.WB_REG_WRITE),
        .wbRd        (bus.WB_RD),
        .fwdSel      (fwdB)
    );

    assign bus.IF_DE_VALID  = ifDeValid;
    assign bus.DE_EX_VALID  = deExValid;
    assign bus.EX_MEM_VALID = exMemValid;
    assign bus.MEM_WB_VALID = memWbValid;
    assign bus.FWD_A_SEL    = FWD_W'(fwdA);
    assign bus.FWD_B_SEL    = FWD_W'(fwdB);
    // Store enable stays up through a freeze; the memory decides completion.
    assign bus.DMEM_WE      = exMemValid && bus.MEM_MEM_WRITE;
    assign bus.RF_WE        = memWbValid && bus.WB_REG_WRITE;
    assign bus.STALL_CNT    = stallCnt;
    assign bus.FLUSH_CNT    = flushCnt;

    // EX write-back flag is carried on the bus but not needed for sequencing.
    assign unusedSigs = bus.EX_REG_WRITE;

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otter_pipe_ctrl
// Scenario bench for otter_pipe_ctrl. Each cycle the expected status vector
// {STALL_PC..STALL_WB, valids, FWD_A, FWD_B, DMEM_WE, RF_WE} (and optionally the
// counters) is queued when stimulus is driven and popped at the falling edge.
// Counters are built 4 bits wide so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_otter_pipe_ctrl;

    localparam int unsigned CNT_W = 4;

    typedef struct {
        string            tag;
        logic [15:0]      vec;
        bit               chkCnt;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic CLK;
    logic RESET_N;
    exp_t sbq[$];
    exp_t e;
    int   nCmp;
    int   nBad;

    otter_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    otter_pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] obs();
        return {bus.STALL_PC, bus.STALL_IF, bus.STALL_DE, bus.STALL_EX, bus.STALL_MEM, bus.STALL_WB,
                bus.IF_DE_VALID, bus.DE_EX_VALID, bus.EX_MEM_VALID, bus.MEM_WB_VALID,
                bus.FWD_A_SEL, bus.FWD_B_SEL, bus.DMEM_WE, bus.RF_WE};
    endfunction

    function automatic logic [15:0] mk(logic [5:0] st, logic [3:0] v, logic [1:0] a,
                                       logic [1:0] b, logic dwe, logic rwe);
        return {st, v, a, b, dwe, rwe};
    endfunction

    function automatic exp_t ex(string tag, logic [15:0] vec, bit chk,
                                logic [CNT_W-1:0] sc, logic [CNT_W-1:0] fc);
        exp_t r;
        r.tag = tag; r.vec = vec; r.chkCnt = chk; r.sc = sc; r.fc = fc;
        return r;
    endfunction

    task automatic drive_idle();
        bus.DE_RS1 = '0; bus.DE_RS2 = '0; bus.DE_RS1_USED = 0; bus.DE_RS2_USED = 0;
        bus.EX_RS1 = '0; bus.EX_RS2 = '0; bus.EX_RS1_USED = 0; bus.EX_RS2_USED = 0;
        bus.EX_RD = '0; bus.EX_REG_WRITE = 0; bus.EX_MEM_READ = 0; bus.BR_TAKEN = 0;
        bus.MEM_RD = '0; bus.MEM_REG_WRITE = 0; bus.MEM_MEM_READ = 0; bus.MEM_MEM_WRITE = 0;
        bus.WB_RD = '0; bus.WB_REG_WRITE = 0; bus.MEM_BUSY = 0; bus.CNT_CLR = 0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Four hazard-free edges leave all stage valids set.
    task automatic settle();
        drive_idle();
        repeat (4) next_cycle();
    endtask

    task automatic test_reset();
        drive_idle();
        sbq.push_back(ex("reset_state", 16'h0000, 1, 0, 0));
        @(negedge CLK);
        e = sbq.pop_front();
        nCmp++;
        if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
        nCmp++;
        if ({bus.STALL_CNT, bus.FLUSH_CNT} !== {e.sc, e.fc}) begin
            nBad++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", e.tag, bus.STALL_CNT, bus.FLUSH_CNT, e.sc, e.fc);
        end
        next_cycle();
        RESET_N = 1'b1;
        bus.WB_REG_WRITE = 1'b1;
        bus.MEM_MEM_WRITE = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            sbq.push_back(ex($sformatf("fill_c%0d", k),
                             mk(6'b0, {k >= 1, k >= 2, k >= 3, k >= 4}, 2'd0, 2'd0, k >= 3, k >= 4), 1, 0, 0));
            @(negedge CLK);
            e = sbq.pop_front();
            nCmp++;
            if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
            if (e.chkCnt) begin
                nCmp++;
                if ({bus.STALL_CNT, bus.FLUSH_CNT} !== {e.sc, e.fc}) begin
                    nBad++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", e.tag, bus.STALL_CNT, bus.FLUSH_CNT, e.sc, e.fc);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            case (c)
                0: begin   // load x5 in EX, DE reads x5 as rs2
                    bus.EX_MEM_READ = 1; bus.EX_REG_WRITE = 1; bus.EX_RD = 5'd5;
                    bus.DE_RS2 = 5'd5; bus.DE_RS2_USED = 1;
                    sbq.push_back(ex("lu_stall", mk(6'b111000, 4'b1111, 0, 0, 0, 0), 1, 0, 0));
                end
                1: begin   // bubble in EX, load in EX/MEM
                    bus.MEM_RD = 5'd5; bus.MEM_REG_WRITE = 1; bus.MEM_MEM_READ = 1;
                    sbq.push_back(ex("lu_bubble", mk(6'b0, 4'b1011, 0, 0, 0, 0), 1, 1, 0));
                end
                default: begin   // consumer in EX, load in MEM/WB
                    bus.EX_RS2 = 5'd5; bus.EX_RS2_USED = 1; bus.WB_RD = 5'd5; bus.WB_REG_WRITE = 1;
                    sbq.push_back(ex("lu_fwd", mk(6'b0, 4'b1101, 0, 2, 0, 1), 1, 1, 0));
                end
            endcase
            @(negedge CLK);
            e = sbq.pop_front();
            nCmp++;
            if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
            if (e.chkCnt) begin
                nCmp++;
                if ({bus.STALL_CNT, bus.FLUSH_CNT} !== {e.sc, e.fc}) begin
                    nBad++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", e.tag, bus.STALL_CNT, bus.FLUSH_CNT, e.sc, e.fc);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        settle();
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            case (c)
                0: begin   // taken branch plus a load-use pattern that must be ignored
                    bus.BR_TAKEN = 1; bus.EX_MEM_READ = 1; bus.EX_RD = 5'd3;
                    bus.DE_RS1 = 5'd3; bus.DE_RS1_USED = 1;
                    sbq.push_back(ex("flush_cyc", mk(6'b0, 4'b1111, 0, 0, 0, 0), 1, 1, 0));
                end
                1: begin   // BR_TAKEN with DE/EX empty is not a flush
                    bus.BR_TAKEN = 1;
                    sbq.push_back(ex("flush_after", mk(6'b0, 4'b0011, 0, 0, 0, 0), 1, 1, 1));
                end
                default: begin
                    sbq.push_back(ex("flush_refill", mk(6'b0, 4'b1001, 0, 0, 0, 0), 1, 1, 1));
                end
            endcase
            @(negedge CLK);
            e = sbq.pop_front();
            nCmp++;
            if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
            if (e.chkCnt) begin
                nCmp++;
                if ({bus.STALL_CNT, bus.FLUSH_CNT} !== {e.sc, e.fc}) begin
                    nBad++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", e.tag, bus.STALL_CNT, bus.FLUSH_CNT, e.sc, e.fc);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_freeze();
        settle();
        for (int c = 0; c < 6; c++) begin
            drive_idle();
            if (c == 0) begin
                bus.CNT_CLR = 1;
                sbq.push_back(ex("frz_clr", mk(6'b0, 4'b1111, 0, 0, 0, 0), 1, 1, 1));
            end else if (c <= 3) begin
                bus.BR_TAKEN = 1; bus.MEM_BUSY = 1; bus.MEM_MEM_WRITE = 1;
                sbq.push_back(ex($sformatf("frz_c%0d", c), mk(6'b111111, 4'b1111, 0, 0, 1, 0),
                                 1, CNT_W'(c - 1), 0));
            end else if (c == 4) begin
                bus.BR_TAKEN = 1; bus.MEM_MEM_WRITE = 1;
                sbq.push_back(ex("frz_release", mk(6'b0, 4'b1111, 0, 0, 1, 0), 1, 3, 0));
            end else begin
                sbq.push_back(ex("frz_flushed", mk(6'b0, 4'b0011, 0, 0, 0, 0), 1, 3, 1));
            end
            @(negedge CLK);
            e = sbq.pop_front();
            nCmp++;
            if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
            if (e.chkCnt) begin
                nCmp++;
                if ({bus.STALL_CNT, bus.FLUSH_CNT} !== {e.sc, e.fc}) begin
                    nBad++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", e.tag, bus.STALL_CNT, bus.FLUSH_CNT, e.sc, e.fc);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_forwarding();
        // {exRs1, u1, exRs2, u2, memRd, memRw, memMr, wbRd, wbRw, expA, expB}
        int t [6][11] = '{
            '{7, 1, 0, 0, 7, 1, 0, 7, 1, 1, 0},
            '{7, 1, 7, 1, 7, 1, 1, 7, 1, 2, 2},
            '{0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0},
            '{7, 1, 9, 1, 7, 1, 0, 9, 1, 1, 2},
            '{7, 0, 9, 0, 7, 1, 0, 9, 1, 0, 0},
            '{7, 1, 9, 1, 7, 0, 0, 7, 1, 2, 0}
        };
        settle();
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            bus.EX_RS1 = 5'(t[i][0]); bus.EX_RS1_USED = t[i][1][0];
            bus.EX_RS2 = 5'(t[i][2]); bus.EX_RS2_USED = t[i][3][0];
            bus.MEM_RD = 5'(t[i][4]); bus.MEM_REG_WRITE = t[i][5][0]; bus.MEM_MEM_READ = t[i][6][0];
            bus.WB_RD = 5'(t[i][7]); bus.WB_REG_WRITE = t[i][8][0];
            sbq.push_back(ex($sformatf("fwd_%0d", i),
                             mk(6'b0, 4'b1111, 2'(t[i][9]), 2'(t[i][10]), 0, t[i][8][0]), 0, 0, 0));
            @(negedge CLK);
            e = sbq.pop_front();
            nCmp++;
            if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
            next_cycle();
        end
    endtask

    task automatic test_saturate();
        settle();
        bus.CNT_CLR = 1;
        next_cycle();
        bus.CNT_CLR = 0;
        bus.MEM_BUSY = 1;
        repeat (20) next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            if (c == 0) begin
                bus.MEM_BUSY = 1;
                sbq.push_back(ex("sat_hold", mk(6'b111111, 4'b1111, 0, 0, 0, 0), 1, 4'hF, 0));
            end else if (c == 1) begin
                bus.MEM_BUSY = 1; bus.CNT_CLR = 1;
                sbq.push_back(ex("sat_clr", mk(6'b111111, 4'b1111, 0, 0, 0, 0), 1, 4'hF, 0));
            end else begin
                sbq.push_back(ex("sat_cleared", mk(6'b0, 4'b1111, 0, 0, 0, 0), 1, 0, 0));
            end
            @(negedge CLK);
            e = sbq.pop_front();
            nCmp++;
            if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
            if (e.chkCnt) begin
                nCmp++;
                if ({bus.STALL_CNT, bus.FLUSH_CNT} !== {e.sc, e.fc}) begin
                    nBad++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", e.tag, bus.STALL_CNT, bus.FLUSH_CNT, e.sc, e.fc);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        settle();
        bus.MEM_BUSY = 1; bus.MEM_MEM_WRITE = 1; bus.WB_REG_WRITE = 1;
        sbq.push_back(ex("mid_busy", mk(6'b111111, 4'b1111, 0, 0, 1, 1), 1, 0, 0));
        @(negedge CLK);
        e = sbq.pop_front();
        nCmp++;
        if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
        nCmp++;
        if ({bus.STALL_CNT, bus.FLUSH_CNT} !== {e.sc, e.fc}) begin
            nBad++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", e.tag, bus.STALL_CNT, bus.FLUSH_CNT, e.sc, e.fc);
        end
        next_cycle();
        #2;
        RESET_N = 1'b0;
        sbq.push_back(ex("mid_async_rst", 16'h0000, 1, 0, 0));
        #1;
        e = sbq.pop_front();
        nCmp++;
        if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
        nCmp++;
        if ({bus.STALL_CNT, bus.FLUSH_CNT} !== {e.sc, e.fc}) begin
            nBad++; $display("FAIL %s counters: got %0d/%0d want %0d/%0d", e.tag, bus.STALL_CNT, bus.FLUSH_CNT, e.sc, e.fc);
        end
        next_cycle();
        RESET_N = 1'b1;
        bus.MEM_BUSY = 0;
        for (int k = 0; k <= 4; k++) begin
            sbq.push_back(ex($sformatf("mid_refill_c%0d", k),
                             mk(6'b0, {k >= 1, k >= 2, k >= 3, k >= 4}, 2'd0, 2'd0, k >= 3, k >= 4), 0, 0, 0));
            @(negedge CLK);
            e = sbq.pop_front();
            nCmp++;
            if (obs() !== e.vec) begin nBad++; $display("FAIL %s: status got %b want %b", e.tag, obs(), e.vec); end
            next_cycle();
        end
    endtask

    initial begin
        nCmp = 0;
        nBad = 0;
        RESET_N = 1'b0;
        drive_idle();
        next_cycle();
        test_reset();
        test_load_use();
        test_flush();
        test_freeze();
        test_forwarding();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
